seg7x16_scan: RTL and testbench

//  Eight-digit multiplexed 7-segment display driver, downstream of the sccomp top.

---
 rtl/seg7x16_scan.sv | 91 +++++++++
 tb/tb_seg7x16_scan.sv | 139 +++++++++++++
 2 files changed

// File: rtl/seg7x16_scan.sv
// Eight-digit multiplexed common-anode 7-segment driver; outputs are registered, one cycle after idx/data_reg.
// No backpressure: cs loads unconditionally. Optional leading-zero blanking via SEG7_BLANK_LEADING_ZERO_EN.
module seg7x16_scan #(
   parameter int SCAN_DIV = 16384
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cs,
   input  logic [31:0] i_data,
   output logic [7:0]  o_seg,
   output logic [7:0]  o_sel
);

   localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [CW-1:0] PRE_LAST = CW'(SCAN_DIV - 1);

   logic [31:0]   data_reg;
   logic [CW-1:0] prescaler;
   logic [2:0]    idx;
   logic          tick;
   logic [3:0]    nibble;
   logic [7:0]    seg_nxt;
   logic [7:0]    sel_nxt;

   function automatic logic [7:0] hex_seg(input logic [3:0] n);
      case (n)
         4'h0: hex_seg = 8'hC0;
         4'h1: hex_seg = 8'hF9;
         4'h2: hex_seg = 8'hA4;
         4'h3: hex_seg = 8'hB0;
         4'h4: hex_seg = 8'h99;
         4'h5: hex_seg = 8'h92;
         4'h6: hex_seg = 8'h82;
         4'h7: hex_seg = 8'hF8;
         4'h8: hex_seg = 8'h80;
         4'h9: hex_seg = 8'h90;
         4'hA: hex_seg = 8'h88;
         4'hB: hex_seg = 8'h83;
         4'hC: hex_seg = 8'hC6;
         4'hD: hex_seg = 8'hA1;
         4'hE: hex_seg = 8'h86;
         default: hex_seg = 8'h8E;
      endcase
   endfunction

   assign tick   = (prescaler == PRE_LAST);
   assign nibble = data_reg[4*idx +: 4];

`ifdef SEG7_BLANK_LEADING_ZERO_EN
   logic [2:0] msd;

   // Highest nonzero nibble; stays 0 for an all-zero word so digit 0 is always lit.
   always_comb begin
      msd = 3'd0;
      for (int k = 1; k < 8; k++) begin
         if (data_reg[4*k +: 4] != 4'h0) msd = 3'(k);
      end
   end

   always_comb begin
      sel_nxt = ~(8'b1 << idx);
      seg_nxt = hex_seg(nibble);
      if (idx > msd) begin
         sel_nxt = 8'hFF;
         seg_nxt = 8'hFF;
      end
   end
`else
   always_comb begin
      sel_nxt = ~(8'b1 << idx);
      seg_nxt = hex_seg(nibble);
   end
`endif

   always_ff @(posedge clk) begin
      if (!rst) begin
         data_reg  <= 32'h0;
         prescaler <= '0;
         idx       <= 3'd0;
         o_seg     <= 8'hFF;
         o_sel     <= 8'hFF;
      end else begin
         if (cs) data_reg <= i_data;
         prescaler <= tick ? '0 : prescaler + 1'b1;
         if (tick) idx <= idx + 3'd1;
         o_sel <= sel_nxt;
         o_seg <= seg_nxt;
      end
   end

endmodule

// File: tb/tb_seg7x16_scan.sv
// Directed bench for seg7x16_scan at SCAN_DIV=4; expected values are hand-derived cycle by cycle.
module tb_seg7x16_scan;

   logic        clk = 1'b0;
   logic        rst;
   logic        cs;
   logic [31:0] i_data;
   logic [7:0]  o_seg;
   logic [7:0]  o_sel;

   int total = 0;
   int bad   = 0;

   logic [7:0] sel_exp [8] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
   // Segments for 32'h0123_4567, indexed by digit.
   logic [7:0] seg_walk [8] = '{8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0};

   seg7x16_scan #(.SCAN_DIV(4)) dut (
      .clk    (clk),
      .rst    (rst),
      .cs     (cs),
      .i_data (i_data),
      .o_seg  (o_seg),
      .o_sel  (o_sel)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int d;
      rst = 1'b0; cs = 1'b0; i_data = 32'h0;

      repeat (3) begin
         step();
         chk("rst_seg", 32'(o_seg), 32'hFF);
         chk("rst_sel", 32'(o_sel), 32'hFF);
      end
      rst = 1'b1;
      step();
      chk("first_sel", 32'(o_sel), 32'hFE);
      chk("first_seg", 32'(o_seg), 32'hC0);

      cs = 1'b1; i_data = 32'h0123_4567;
      step();
      cs = 1'b0;
      chk("load_latency_seg", 32'(o_seg), 32'hC0);
      step(); step();
      chk("load_seg", 32'(o_seg), 32'hF8);
      chk("load_sel", 32'(o_sel), 32'hFE);

      // Full frame starting at digit 1, wrapping back to digit 0.
      for (int c = 0; c < 32; c++) begin
         step();
         d = ((c / 4) + 1) % 8;
         chk("walk_sel", 32'(o_sel), 32'(sel_exp[d]));
         chk("walk_seg", 32'(o_seg), 32'(seg_walk[d]));
         chk("walk_onehot", 32'($countones(~o_sel)), 32'd1);
      end

      step(); step(); step();
      chk("pre_tick_sel", 32'(o_sel), 32'hFD);
      cs = 1'b1; i_data = 32'hFFFF_FFFF;
      step();
      cs = 1'b0;
      chk("tick_edge_seg", 32'(o_seg), 32'h82);
      step();
      chk("cs_tick_sel", 32'(o_sel), 32'hFB);
      chk("cs_tick_seg", 32'(o_seg), 32'h8E);

      cs = 1'b1; i_data = 32'h0123_4567;
      step();
      cs = 1'b0;
      repeat (11) step();
      chk("mid_idx5_sel", 32'(o_sel), 32'hDF);
      chk("mid_idx5_seg", 32'(o_seg), 32'hA4);
      rst = 1'b0;
      step();
      chk("mid_rst_seg", 32'(o_seg), 32'hFF);
      chk("mid_rst_sel", 32'(o_sel), 32'hFF);
      rst = 1'b1;
      step();
      chk("post_rst_sel", 32'(o_sel), 32'hFE);
      chk("post_rst_seg", 32'(o_seg), 32'hC0);

      step();
      cs = 1'b1; i_data = 32'h0000_00A5;
      step();
      cs = 1'b0;
      step();
      chk("a5_d0_sel", 32'(o_sel), 32'hFE);
      chk("a5_d0_seg", 32'(o_seg), 32'h92);
      repeat (4) step();
      chk("a5_d1_sel", 32'(o_sel), 32'hFD);
      chk("a5_d1_seg", 32'(o_seg), 32'h88);
      for (int k = 2; k < 8; k++) begin
         repeat (4) step();
`ifdef SEG7_BLANK_LEADING_ZERO_EN
         chk("a5_lead_sel", 32'(o_sel), 32'hFF);
         chk("a5_lead_seg", 32'(o_seg), 32'hFF);
`else
         chk("a5_lead_sel", 32'(o_sel), 32'(sel_exp[k]));
         chk("a5_lead_seg", 32'(o_seg), 32'hC0);
`endif
      end

      cs = 1'b1; i_data = 32'h0;
      step();
      cs = 1'b0;
      chk("zero_prev_seg", 32'(o_seg), 32'h92);
      step();
      chk("zero_d0_sel", 32'(o_sel), 32'hFE);
      chk("zero_d0_seg", 32'(o_seg), 32'hC0);
      repeat (4) step();
`ifdef SEG7_BLANK_LEADING_ZERO_EN
      chk("zero_d1_sel", 32'(o_sel), 32'hFF);
      chk("zero_d1_seg", 32'(o_seg), 32'hFF);
`else
      chk("zero_d1_sel", 32'(o_sel), 32'hFD);
      chk("zero_d1_seg", 32'(o_seg), 32'hC0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
